alu_muldiv_seq: RTL and testbench



---
 rtl/alu_muldiv_seq_if.sv | 32 +++
 rtl/alu_muldiv_seq.sv | 120 ++++++++++++
 tb/tb_alu_muldiv_seq.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_seq_if.sv
// Handshake, result and ALU-drive bundle for the multi-cycle MULTU/DIVU sequencer.
// slave = sequencer side; master = requester and ALU side.
interface alu_muldiv_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_cin;
  logic             alu_binv;
  logic [1:0]       alu_sel;
  logic [WIDTH-1:0] alu_result;
  logic             alu_co;

  modport slave (
    input  start, op, opa, opb, alu_result, alu_co,
    output busy, done, hi, lo, div_by_zero, alu_a, alu_b, alu_cin, alu_binv, alu_sel
  );

  modport master (
    output start, op, opa, opb, alu_result, alu_co,
    input  busy, done, hi, lo, div_by_zero, alu_a, alu_b, alu_cin, alu_binv, alu_sel
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Unsigned 32x32 multiply / 32/32 divide sequencer borrowing the datapath ALU,
// one shift-add or restoring-subtract step per clock; results in hi/lo.
module alu_muldiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input logic                clk,
  input logic                rst_n,
  alu_muldiv_seq_if.slave    bus
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  count_q;
  logic             op_q;
  logic [WIDTH-1:0] acc_q, acc_d;   // P (mul) / R (div)
  logic [WIDTH-1:0] dvs_q;          // M (mul) / D (div)
  logic [WIDTH-1:0] quo_q, quo_d;   // Q: multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             dbz_q;
  logic             start_dbz;

  assign start_dbz = bus.op && (bus.opb == '0);

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    quo_d        = quo_q;
    bus.alu_a    = '0;
    bus.alu_b    = '0;
    bus.alu_sel  = 2'b00;
    bus.alu_binv = 1'b0;
    bus.alu_cin  = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) state_d = start_dbz ? StDone : StIter;
      end
      StIter: begin
        bus.alu_sel = 2'b10;
        bus.alu_b   = dvs_q;
        if (!op_q) begin
          bus.alu_a = acc_q;
          if (quo_q[0]) begin
            {acc_d, quo_d} = {bus.alu_co, bus.alu_result, quo_q[WIDTH-1:1]};
          end else begin
            {acc_d, quo_d} = {1'b0, acc_q, quo_q[WIDTH-1:1]};
          end
        end else begin
          // Shifted remainder is 33 bits; its MSB is acc_q[WIDTH-1], so a set
          // MSB means the subtraction always fits regardless of the ALU carry.
          bus.alu_a    = {acc_q[WIDTH-2:0], quo_q[WIDTH-1]};
          bus.alu_binv = 1'b1;
          bus.alu_cin  = 1'b1;
          if (acc_q[WIDTH-1] || bus.alu_co) begin
            acc_d = bus.alu_result;
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {acc_q[WIDTH-2:0], quo_q[WIDTH-1]};
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
        end
        if (count_q == LastCnt) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      count_q <= '0;
      op_q    <= 1'b0;
      acc_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            op_q    <= bus.op;
            count_q <= '0;
            acc_q   <= '0;
            dvs_q   <= bus.op ? bus.opb : bus.opa;
            quo_q   <= bus.op ? bus.opa : bus.opb;
            dbz_q   <= start_dbz;
            if (start_dbz) begin
              hi_q <= bus.opa;
              lo_q <= '1;
            end
          end
        end
        StIter: begin
          count_q <= count_q + 1'b1;
          acc_q   <= acc_d;
          quo_q   <= quo_d;
          if (count_q == LastCnt) begin
            hi_q <= acc_d;
            lo_q <= quo_d;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state_q == StIter);
  assign bus.done        = (state_q == StDone);
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: behavioural ALU, directed vector table, hand-written
// multi-cycle sequences, and random ops against an arithmetic reference model.
module tb_alu_muldiv_seq;

  logic clk;
  logic rst_n;
  alu_muldiv_seq_if #(.WIDTH(32)) bus ();

  alu_muldiv_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath ALU: AND / OR / add (with optional b inversion) / slt with less tied 0.
  logic [31:0] alu_bop;
  logic [32:0] alu_sum;
  always_comb begin
    alu_bop = bus.alu_binv ? ~bus.alu_b : bus.alu_b;
    alu_sum = {1'b0, bus.alu_a} + {1'b0, alu_bop} + {32'b0, bus.alu_cin};
    bus.alu_co = alu_sum[32];
    case (bus.alu_sel)
      2'b00:   bus.alu_result = bus.alu_a & alu_bop;
      2'b01:   bus.alu_result = bus.alu_a | alu_bop;
      2'b10:   bus.alu_result = alu_sum[31:0];
      default: bus.alu_result = '0;
    endcase
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model(input logic op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo,
                                output logic dbz);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    dbz = 1'b0;
    if (!op) begin
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 0) begin
      hi  = a;
      lo  = 32'hFFFF_FFFF;
      dbz = 1'b1;
    end else begin
      hi = a % b;
      lo = a / b;
    end
  endfunction

  // Call at a negedge: start is seen by the next posedge and then dropped.
  task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.opa   = a;
    bus.opb   = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Counts negedges until done; returns at the negedge where done is seen.
  task automatic wait_done(output int lat, output int busy_n, output logic [1:0] sel0,
                           output logic binv0, output logic cin0, output bit ok);
    lat = 0; busy_n = 0; ok = 0; sel0 = 2'b00; binv0 = 1'b0; cin0 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (bus.done) begin
        ok = 1;
        break;
      end
      if (bus.busy) begin
        if (busy_n == 0) begin
          sel0  = bus.alu_sel;
          binv0 = bus.alu_binv;
          cin0  = bus.alu_cin;
        end
        busy_n++;
      end
    end
    if (!ok) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_check(input string name, input logic op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] ehi,
                           input logic [31:0] elo, input logic edbz);
    int lat, busy_n;
    logic [1:0] sel0;
    logic binv0, cin0;
    bit ok;
    issue(op, a, b);
    wait_done(lat, busy_n, sel0, binv0, cin0, ok);
    if (ok) begin
      check({name, ".latency"}, 64'(lat), (edbz ? 64'd1 : 64'd33));
      check({name, ".busy_cycles"}, 64'(busy_n), (edbz ? 64'd0 : 64'd32));
      check({name, ".hi"}, {32'b0, bus.hi}, {32'b0, ehi});
      check({name, ".lo"}, {32'b0, bus.lo}, {32'b0, elo});
      check({name, ".dbz"}, {63'b0, bus.div_by_zero}, {63'b0, edbz});
      if (!edbz) check({name, ".alu_ctl"}, {61'b0, sel0, binv0, cin0},
                       {61'b0, 2'b10, op, op});
      @(negedge clk);
      check({name, ".done_pulse"}, {62'b0, bus.done, bus.busy}, 64'd0);
      check({name, ".hold"}, {bus.hi, bus.lo}, {ehi, elo});
    end
  endtask

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int lat, busy_n;
    logic [1:0] sel0;
    logic binv0, cin0;
    bit ok;
    logic [31:0] ehi, elo, ra, rb;
    logic edbz, rop;

    vecs[0] = '{1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 32'h38E3_8E38, 32'h71C7_1C72, 1'b0};
    vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[2] = '{1'b0, 32'h0000_0000, 32'h1234_5678, 32'h0, 32'h0, 1'b0};
    vecs[3] = '{1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0};
    vecs[4] = '{1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 32'h1, 1'b0};
    vecs[5] = '{1'b1, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1};

    bus.start = 1'b0; bus.op = 1'b0; bus.opa = '0; bus.opb = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.outs", {58'b0, bus.busy, bus.done, bus.div_by_zero, bus.alu_sel, bus.alu_cin},
          64'd0);
    check("reset.hilo", {bus.hi, bus.lo}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].hi, vecs[i].lo, vecs[i].dbz);

    // A fresh start clears the sticky divide-by-zero flag once accepted.
    issue(1'b0, 32'd6, 32'd7);
    @(negedge clk);
    check("dbz_clear", {62'b0, bus.div_by_zero, bus.busy}, 64'd1);
    wait_done(lat, busy_n, sel0, binv0, cin0, ok);
    check("dbz_clear.lo", {32'b0, bus.lo}, 64'd42);
    @(negedge clk);

    // Starts during ITER and DONE are ignored.
    issue(1'b0, 32'hAAAA_AAAA, 32'h5555_5555);
    repeat (10) @(negedge clk);
    issue(1'b1, 32'd7, 32'd0);
    wait_done(lat, busy_n, sel0, binv0, cin0, ok);
    check("ignore.latency", 64'(lat), 64'd23);
    bus.start = 1'b1; bus.op = 1'b1; bus.opa = 32'd9; bus.opb = 32'd0;
    @(negedge clk);
    bus.start = 1'b0;
    check("ignore.idle", {62'b0, bus.busy, bus.div_by_zero}, 64'd0);
    check("ignore.result", {bus.hi, bus.lo}, 64'h38E3_8E38_71C7_1C72);
    @(negedge clk);
    check("ignore.still_idle", {63'b0, bus.busy}, 64'd0);

    // start held high re-triggers one cycle after done.
    bus.start = 1'b1; bus.op = 1'b0; bus.opa = 32'd3; bus.opb = 32'd5;
    wait_done(lat, busy_n, sel0, binv0, cin0, ok);
    @(negedge clk);
    check("b2b.idle_gap", {62'b0, bus.busy, bus.done}, 64'd0);
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b.restart", {63'b0, bus.busy}, 64'd1);
    wait_done(lat, busy_n, sel0, binv0, cin0, ok);
    check("b2b.result", {bus.hi, bus.lo}, 64'd15);
    @(negedge clk);

    // Reset mid-operation aborts immediately.
    run_check("pre_abort", 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5677, 32'hEDCB_A988,
              1'b0);
    issue(1'b1, 32'hDEAD_BEEF, 32'd3);
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort.ctl", {57'b0, bus.busy, bus.done, bus.alu_sel, bus.alu_binv, bus.alu_cin},
          64'd0);
    check("abort.alu_ab", {bus.alu_a, bus.alu_b}, 64'd0);
    check("abort.hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_check("post_abort", 1'b0, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);

    // Random ops against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      rop = 1'($urandom_range(0, 1));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1, 2:    rb = $urandom_range(1, 255);
        default: rb = $urandom;
      endcase
      model(rop, ra, rb, ehi, elo, edbz);
      run_check($sformatf("rand%0d", i), rop, ra, rb, ehi, elo, edbz);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
